// File: rtl/out_alu_control_unit.sv
// Return path of the ALU datapath: one-entry holding registers for the ADD and
// MUL results, round-robin arbitrated into FIFO_OUT at one word per cycle.
module out_alu_control_unit #(
  parameter int DATA_SIZE      = 16,
  parameter int ID_SIZE        = 8,
  parameter int OPERATION_SIZE = 2,
  parameter int COUNT_WIDTH    = 8,
  parameter int FIFO_OUT_WIDTH = DATA_SIZE + ID_SIZE + OPERATION_SIZE
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      a_valid_result,
  input  logic [DATA_SIZE-1:0]      a_result,
  input  logic [ID_SIZE-1:0]        a_id,
  output logic                      a_ready_result,
  input  logic                      m_valid_result,
  input  logic [DATA_SIZE-1:0]      m_result,
  input  logic [ID_SIZE-1:0]        m_id,
  output logic                      m_ready_result,
  input  logic                      full_out,
  output logic                      w_en_out,
  output logic [FIFO_OUT_WIDTH-1:0] fifo_wdata,
  output logic                      op_done,
  output logic [COUNT_WIDTH-1:0]    wr_count
);

  localparam logic [OPERATION_SIZE-1:0] OP_ADD = OPERATION_SIZE'(1);
  localparam logic [OPERATION_SIZE-1:0] OP_MUL = OPERATION_SIZE'(2);

  logic                 a_hold_v, m_hold_v, rr_ptr;
  logic [DATA_SIZE-1:0] a_hold_result, m_hold_result;
  logic [ID_SIZE-1:0]   a_hold_id, m_hold_id;
  logic                 grant_a, grant_m;
  logic                 a_capture, m_capture;

  // Ready depends only on registered state, never on full_out.
  assign a_ready_result = !a_hold_v;
  assign m_ready_result = !m_hold_v;
  assign a_capture      = a_valid_result && a_ready_result;
  assign m_capture      = m_valid_result && m_ready_result;
  assign op_done        = w_en_out;

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment, otherwise the tool infers a latch.
  always_comb begin
    grant_a    = a_hold_v && (!m_hold_v || !rr_ptr);
    grant_m    = m_hold_v && !grant_a;
    w_en_out   = (a_hold_v || m_hold_v) && !full_out;
    fifo_wdata = '0;
    if (grant_a)      fifo_wdata = {a_hold_result, a_hold_id, OP_ADD};
    else if (grant_m) fifo_wdata = {m_hold_result, m_hold_id, OP_MUL};
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_hold_v <= 1'b0;
      m_hold_v <= 1'b0;
      rr_ptr   <= 1'b0;
      wr_count <= '0;
    end else begin
      if (a_capture)                 a_hold_v <= 1'b1;
      else if (w_en_out && grant_a)  a_hold_v <= 1'b0;
      if (m_capture)                 m_hold_v <= 1'b1;
      else if (w_en_out && grant_m)  m_hold_v <= 1'b0;
      if (w_en_out)                  wr_count <= wr_count + COUNT_WIDTH'(1);
      // Fairness pointer only moves when there was actual contention.
      if (w_en_out && a_hold_v && m_hold_v) rr_ptr <= !rr_ptr;
    end
  end

  // NOTE: payload registers are deliberately not reset; they are qualified by
  // the hold_v flags, and fifo_wdata is forced to 0 while no hold is valid.
  always_ff @(posedge clk) begin
    if (a_capture) begin
      a_hold_result <= a_result;
      a_hold_id     <= a_id;
    end
    if (m_capture) begin
      m_hold_result <= m_result;
      m_hold_id     <= m_id;
    end
  end

endmodule

// File: tb/tb_out_alu_control_unit.sv
// Directed bench for out_alu_control_unit: inputs change and outputs are
// sampled on the falling clock edge, away from the active rising edge.
module tb_out_alu_control_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_valid_result, m_valid_result;
  logic [15:0] a_result, m_result;
  logic [7:0]  a_id, m_id;
  logic        a_ready_result, m_ready_result;
  logic        full_out, w_en_out, op_done;
  logic [25:0] fifo_wdata;
  logic [7:0]  wr_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  out_alu_control_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .a_valid_result (a_valid_result),
    .a_result       (a_result),
    .a_id           (a_id),
    .a_ready_result (a_ready_result),
    .m_valid_result (m_valid_result),
    .m_result       (m_result),
    .m_id           (m_id),
    .m_ready_result (m_ready_result),
    .full_out       (full_out),
    .w_en_out       (w_en_out),
    .fifo_wdata     (fifo_wdata),
    .op_done        (op_done),
    .wr_count       (wr_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [25:0] exp_w;
    logic [15:0] res;

    rst_n = 1'b0;
    a_valid_result = 1'b0; m_valid_result = 1'b0;
    a_result = '0; m_result = '0; a_id = '0; m_id = '0;
    full_out = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_w_en",    w_en_out, 0);
    check("rst_op_done", op_done, 0);
    check("rst_wdata",   fifo_wdata, 0);
    check("rst_count",   wr_count, 0);
    check("rst_a_ready", a_ready_result, 1);
    check("rst_m_ready", m_ready_result, 1);
    rst_n = 1'b1;

    // Test 1: reset while a hold is full discards it
    @(negedge clk);
    full_out = 1'b1;
    a_valid_result = 1'b1; a_result = 16'h1234; a_id = 8'h77;
    @(negedge clk);
    a_valid_result = 1'b0;
    check("t1_held_a_ready", a_ready_result, 0);
    check("t1_full_w_en",    w_en_out, 0);
    rst_n = 1'b0;
    #1;
    check("t1_rst_w_en",    w_en_out, 0);
    check("t1_rst_a_ready", a_ready_result, 1);
    check("t1_rst_m_ready", m_ready_result, 1);
    check("t1_rst_count",   wr_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    full_out = 1'b0;
    #1;
    check("t1_rel_w_en",    w_en_out, 0);
    check("t1_rel_wdata",   fifo_wdata, 0);
    check("t1_rel_a_ready", a_ready_result, 1);
    check("t1_rel_m_ready", m_ready_result, 1);
    @(negedge clk);
    check("t1_no_write", w_en_out, 0);
    check("t1_count",    wr_count, 0);

    // Test 2: single ADD
    a_valid_result = 1'b1; a_result = 16'h00FF; a_id = 8'h05;
    @(negedge clk);
    a_valid_result = 1'b0;
    check("t2_w_en",    w_en_out, 1);
    check("t2_op_done", op_done, 1);
    check("t2_wdata",   fifo_wdata, {16'h00FF, 8'h05, 2'b01});
    check("t2_a_ready", a_ready_result, 0);
    check("t2_count_before", wr_count, 0);
    @(negedge clk);
    check("t2_w_en_after", w_en_out, 0);
    check("t2_count",      wr_count, 1);
    check("t2_a_ready_after", a_ready_result, 1);

    // Test 3: single MUL, with an ADD captured on the MUL write edge
    m_valid_result = 1'b1; m_result = 16'h0C35; m_id = 8'hA0;
    @(negedge clk);
    m_valid_result = 1'b0;
    check("t3_w_en",    w_en_out, 1);
    check("t3_op_done", op_done, 1);
    check("t3_wdata",   fifo_wdata, {16'h0C35, 8'hA0, 2'b10});
    check("t3_m_ready", m_ready_result, 0);
    a_valid_result = 1'b1; a_result = 16'h1111; a_id = 8'h11;
    @(negedge clk);
    a_valid_result = 1'b0;
    check("t3_count",       wr_count, 2);
    check("t3_m_ready_rel", m_ready_result, 1);
    check("t3_wdata_add",   fifo_wdata, {16'h1111, 8'h11, 2'b01});
    @(negedge clk);
    check("t3_op_done_low", op_done, 0);
    check("t3_count2",      wr_count, 3);

    // Test 4: simultaneous ADD/MUL, round-robin order
    do_reset();
    a_valid_result = 1'b1; a_result = 16'h0101; a_id = 8'h01;
    m_valid_result = 1'b1; m_result = 16'h0202; m_id = 8'h02;
    @(negedge clk);
    a_valid_result = 1'b0; m_valid_result = 1'b0;
    check("t4_first_add",  fifo_wdata, {16'h0101, 8'h01, 2'b01});
    check("t4_m_ready",    m_ready_result, 0);
    @(negedge clk);
    check("t4_second_mul", fifo_wdata, {16'h0202, 8'h02, 2'b10});
    check("t4_second_wen", w_en_out, 1);
    @(negedge clk);
    check("t4_idle", w_en_out, 0);
    a_valid_result = 1'b1; a_result = 16'h0303; a_id = 8'h03;
    m_valid_result = 1'b1; m_result = 16'h0404; m_id = 8'h04;
    @(negedge clk);
    a_valid_result = 1'b0; m_valid_result = 1'b0;
    check("t4_rr_first_mul",  fifo_wdata, {16'h0404, 8'h04, 2'b10});
    @(negedge clk);
    check("t4_rr_second_add", fifo_wdata, {16'h0303, 8'h03, 2'b01});
    @(negedge clk);
    check("t4_idle2", w_en_out, 0);
    check("t4_count", wr_count, 4);

    // Test 5: backpressure with both holds valid
    full_out = 1'b1;
    a_valid_result = 1'b1; a_result = 16'h5555; a_id = 8'h05;
    m_valid_result = 1'b1; m_result = 16'h6666; m_id = 8'h06;
    @(negedge clk);
    a_valid_result = 1'b0; m_valid_result = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("t5_full_w_en",    w_en_out, 0);
      check("t5_full_a_ready", a_ready_result, 0);
      check("t5_full_m_ready", m_ready_result, 0);
      @(negedge clk);
    end
    full_out = 1'b0;
    #1;
    check("t5_rel_w_en", w_en_out, 1);
    check("t5_rel_add",  fifo_wdata, {16'h5555, 8'h05, 2'b01});
    @(negedge clk);
    check("t5_rel_mul",  fifo_wdata, {16'h6666, 8'h06, 2'b10});
    check("t5_rel_w_en2", w_en_out, 1);
    @(negedge clk);
    check("t5_idle",  w_en_out, 0);
    check("t5_count", wr_count, 6);

    // Test 6: 256 ADD writes, counter wraps, ids in order
    do_reset();
    for (int i = 0; i < 256; i++) begin
      res = 16'(i * 3 + 16'h0100);
      a_valid_result = 1'b1; a_result = res; a_id = 8'(i);
      @(negedge clk);
      a_valid_result = 1'b0;
      exp_w = {res, 8'(i), 2'b01};
      check("t6_word", fifo_wdata, exp_w);
      if (i == 255) check("t6_count_255", wr_count, 255);
      @(negedge clk);
    end
    check("t6_wrap", wr_count, 0);
    check("t6_idle", w_en_out, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
